// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//    Shared definitions for the serial adder datapath: default operand width
//    and the loader/control state encoding.
package serial_add_pkg;

   // Default operand width for the accumulator, addend and loader.
   localparam int unsigned SerialWidth = 4;

   // Loader state: waiting for a pair, or serialising a word.
   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } serial_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg
//    Parallel-in serial-out shift register, LSB first, zero fill from the MSB.
//    A load takes priority over a shift on the same edge.
// Ports:
//    CLK    rising-edge clock
//    RSTn   asynchronous active-low reset, clears the register
//    load   capture d on the next edge
//    shift  shift right by one on the next edge (ignored while load is high)
//    d      parallel load value
//    q0     current serial bit (register bit 0)
module piso_shift_reg
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = SerialWidth
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q0
);

   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = d;
      end else if (shift) begin
         sh_d = {1'b0, sh_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign q0 = sh_q[0];

endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader
//    Feed stage for the serial adder. Accepts an A/B operand pair through a
//    valid/ready handshake into a one-deep pending slot, then serialises each
//    pair LSB first on Xi/Yi with shift enable Sh. first_bit/last_bit mark the
//    word boundaries; done pulses for one cycle after the last bit.
// Ports:
//    CLK        rising-edge clock
//    RSTn       asynchronous active-low reset
//    in_valid   operand pair presented
//    in_ready   pending slot empty (registered)
//    a_in/b_in  operands A (accumulator side) and B (addend side)
//    St         run enable; low stalls the word in place
//    Sh         shift enable to the datapath
//    Xi/Yi      current A/B bit, zero whenever Sh is low
//    first_bit  bit 0 of a word is on Xi/Yi
//    last_bit   bit WIDTH-1 of a word is on Xi/Yi
//    busy       word in progress or pair pending
//    done       one-cycle pulse after the last bit of a word
module serial_operand_loader
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = SerialWidth
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             St,
   output logic             Sh,
   output logic             Xi,
   output logic             Yi,
   output logic             first_bit,
   output logic             last_bit,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

   serial_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0] a_pend_q, a_pend_d;
   logic [WIDTH-1:0] b_pend_q, b_pend_d;
   logic             done_q, done_d;

   logic             sh_en;
   logic             load;
   logic             a_bit;
   logic             b_bit;

   // Shifting only happens in SHIFT with St high; this also gates Xi/Yi.
   assign sh_en = (state_q == StShift) && St;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q;
      a_pend_d     = a_pend_q;
      b_pend_d     = b_pend_q;
      done_d       = 1'b0;
      load         = 1'b0;

      // Acceptance requires an empty slot and loading requires a full one,
      // so the two never collide on the same edge.
      if (in_valid && !pend_valid_q) begin
         pend_valid_d = 1'b1;
         a_pend_d     = a_in;
         b_pend_d     = b_in;
      end

      case (state_q)
         StIdle: begin
            if (pend_valid_q) begin
               load         = 1'b1;
               cnt_d        = '0;
               pend_valid_d = 1'b0;
               state_d      = StShift;
            end
         end
         StShift: begin
            if (St) begin
               if (cnt_q == CntLast) begin
                  done_d = 1'b1;
                  cnt_d  = '0;
                  if (pend_valid_q) begin
                     // Back-to-back word: no idle bubble between words.
                     load         = 1'b1;
                     pend_valid_d = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         a_pend_q     <= '0;
         b_pend_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         a_pend_q     <= a_pend_d;
         b_pend_q     <= b_pend_d;
         done_q       <= done_d;
      end
   end

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_a_sh (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .load  (load),
      .shift (sh_en),
      .d     (a_pend_q),
      .q0    (a_bit)
   );

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_b_sh (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .load  (load),
      .shift (sh_en),
      .d     (b_pend_q),
      .q0    (b_bit)
   );

   assign in_ready  = !pend_valid_q;
   assign Sh        = sh_en;
   assign Xi        = sh_en & a_bit;
   assign Yi        = sh_en & b_bit;
   assign first_bit = sh_en && (cnt_q == '0);
   assign last_bit  = sh_en && (cnt_q == CntLast);
   assign busy      = (state_q == StShift) || pend_valid_q;
   assign done      = done_q;

endmodule
